// File: rtl/vdc_iter_32bit.sv
// vdc_iter_32bit: iterative van der Corput index generator.
// Keeps a 32-bit sequence index and returns its radical inverse in BASE,
// scaled to SCALE digits. Each result takes SCALE cycles to compute.
//
// Ports:
//   clk     in   1  rising-edge clock
//   rst     in   1  asynchronous active-high reset
//   pop     in   1  request next value (taken only while ready=1)
//   reseed  in   1  load the index counter from seed (any state)
//   seed    in  32  new index value
//   ready   out  1  idle and able to take pop
//   valid   out  1  one-cycle pulse; vdc_out/k_out are new
//   vdc_out out 32  radical inverse, 0..BASE**SCALE-1
//   k_out   out 32  index that produced vdc_out
module vdc_iter_32bit #(
  parameter int BASE  = 3,
  parameter int SCALE = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pop,
  input  logic        reseed,
  input  logic [31:0] seed,
  output logic        ready,
  output logic        valid,
  output logic [31:0] vdc_out,
  output logic [31:0] k_out
);

  function automatic logic [63:0] f_pow(input int b, input int e);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < e; i++) p = p * 64'(b);
    return p;
  endfunction

  localparam logic [63:0] LP_RANGE = f_pow(BASE, SCALE);

  // acc must fit in 32 bits, so BASE**SCALE has to stay below 2**32.
  generate
    if (BASE < 2 || BASE > 16 || SCALE < 1 || SCALE > 32 ||
        LP_RANGE >= 64'h1_0000_0000) begin : g_bad_param
      $error("vdc_iter_32bit: illegal BASE/SCALE");
    end
  endgenerate

  localparam logic [5:0]  LP_LAST = 6'(SCALE - 1);
  localparam logic [31:0] LP_BASE = 32'(BASE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t      r_state;
  logic        r_ready;
  logic        r_valid;
  logic [31:0] r_cnt;
  logic [31:0] r_wk;
  logic [31:0] r_acc;
  logic [31:0] r_idx;
  logic [5:0]  r_dc;
  logic [31:0] r_vdc;
  logic [31:0] r_k;

  logic [31:0] w_cnt_next;
  logic [31:0] w_k_new;
  logic [31:0] w_q;
  logic [31:0] w_r;
  logic [31:0] w_acc_next;

  // reseed wins over the stored count when both it and pop arrive in IDLE.
  assign w_cnt_next = reseed ? seed : r_cnt;
  assign w_k_new    = w_cnt_next + 32'd1;

  // Constant divisor: synthesis reduces these to fixed logic.
  assign w_q        = r_wk / LP_BASE;
  assign w_r        = r_wk % LP_BASE;
  // Horner step: the least significant digit of k ends up most significant.
  assign w_acc_next = r_acc * LP_BASE + w_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_cnt   <= '0;
      r_wk    <= '0;
      r_acc   <= '0;
      r_idx   <= '0;
      r_dc    <= '0;
      r_vdc   <= '0;
      r_k     <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_valid <= 1'b0;
          if (pop) begin
            r_cnt   <= w_k_new;
            r_wk    <= w_k_new;
            r_idx   <= w_k_new;
            r_acc   <= '0;
            r_dc    <= '0;
            r_ready <= 1'b0;
            r_state <= S_CALC;
          end else begin
            r_cnt   <= w_cnt_next;
            r_ready <= 1'b1;
          end
        end
        S_CALC: begin
          // Counter may be reseeded; the job in flight uses r_wk/r_idx.
          if (reseed) r_cnt <= seed;
          r_acc <= w_acc_next;
          r_wk  <= w_q;
          r_dc  <= r_dc + 6'd1;
          // Fixed SCALE iterations, even once r_wk has reached zero.
          if (r_dc == LP_LAST) begin
            r_vdc   <= w_acc_next;
            r_k     <= r_idx;
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (reseed) r_cnt <= seed;
          r_valid <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ready   = r_ready;
  assign valid   = r_valid;
  assign vdc_out = r_vdc;
  assign k_out   = r_k;

endmodule

// File: tb/tb_vdc_iter_32bit.sv
// tb_vdc_iter_32bit: self-checking bench for vdc_iter_32bit.
// Two instances (BASE=3/SCALE=7 and BASE=2/SCALE=11) against a digit model.
module tb_vdc_iter_32bit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        pop_a, reseed_a, ready_a, valid_a;
  logic [31:0] seed_a, vdc_a, k_a;
  logic        pop_b, reseed_b, ready_b, valid_b;
  logic [31:0] seed_b, vdc_b, k_b;

  vdc_iter_32bit #(.BASE(3), .SCALE(7)) dut_a (
    .clk(clk), .rst(rst), .pop(pop_a), .reseed(reseed_a),
    .seed(seed_a), .ready(ready_a), .valid(valid_a),
    .vdc_out(vdc_a), .k_out(k_a)
  );

  vdc_iter_32bit #(.BASE(2), .SCALE(11)) dut_b (
    .clk(clk), .rst(rst), .pop(pop_b), .reseed(reseed_b),
    .seed(seed_b), .ready(ready_b), .valid(valid_b),
    .vdc_out(vdc_b), .k_out(k_b)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_cnt_a;
  logic [31:0] m_cnt_b;

  // Digit-by-digit definition: digit i of k weighted by BASE**(SCALE-1-i).
  function automatic logic [31:0] ref_vdc(input logic [31:0] k,
                                          input int base, input int scale);
    longint unsigned kk, w, r, b;
    kk = 64'(k);
    b  = 64'(base);
    r  = 0;
    w  = 1;
    for (int i = 0; i < scale - 1; i++) w = w * b;
    for (int i = 0; i < scale; i++) begin
      r  = r + (kk % b) * w;
      kk = kk / b;
      w  = w / b;
    end
    return r[31:0];
  endfunction

  // Issue one pop on instance `which` (0: base 3, 1: base 2) and wait for
  // valid. lat counts edges from the accepting edge through the valid edge.
  task automatic do_pop(input int which, input logic rs,
                        input logic [31:0] sd, output logic [31:0] vo,
                        output logic [31:0] ko, output int lat);
    int w;
    logic rdy, v;
    w = 0;
    rdy = (which == 0) ? ready_a : ready_b;
    while (!rdy && w < 50) begin
      @(posedge clk); #1;
      w++;
      rdy = (which == 0) ? ready_a : ready_b;
    end
    vo = '0; ko = '0; lat = -1;
    if (!rdy) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_wait dut=%0d: ready stayed 0 for 50 cycles", which);
      return;
    end
    if (which == 0) begin
      pop_a = 1'b1; reseed_a = rs; seed_a = sd;
    end else begin
      pop_b = 1'b1; reseed_b = rs; seed_b = sd;
    end
    @(posedge clk); #1;
    pop_a = 1'b0; reseed_a = 1'b0;
    pop_b = 1'b0; reseed_b = 1'b0;
    lat = 1;
    v = 1'b0;
    while (!v && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      v = (which == 0) ? valid_a : valid_b;
    end
    if (!v) begin
      n_cmp++; n_bad++;
      $display("FAIL valid_wait dut=%0d: no valid within 60 cycles", which);
      lat = -1;
      return;
    end
    vo = (which == 0) ? vdc_a : vdc_b;
    ko = (which == 0) ? k_a : k_b;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++;
    if (ready_a !== 1'b1) begin
      n_bad++; $display("FAIL reset_ready_a got %b want 1", ready_a);
    end
    n_cmp++;
    if (valid_a !== 1'b0) begin
      n_bad++; $display("FAIL reset_valid_a got %b want 0", valid_a);
    end
    n_cmp++;
    if (vdc_a !== 32'd0) begin
      n_bad++; $display("FAIL reset_vdc_a got %0d want 0", vdc_a);
    end
    n_cmp++;
    if (k_a !== 32'd0) begin
      n_bad++; $display("FAIL reset_k_a got %0d want 0", k_a);
    end
    n_cmp++;
    if (ready_b !== 1'b1 || valid_b !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_b ready=%b valid=%b want 1/0", ready_b, valid_b);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    m_cnt_a = '0;
    m_cnt_b = '0;
  endtask

  task automatic test_sequence();
    logic [31:0] vo, ko, ek;
    int lat;
    for (int i = 0; i < 6; i++) begin
      do_pop(0, 1'b0, 32'd0, vo, ko, lat);
      ek = m_cnt_a + 32'd1;
      m_cnt_a = ek;
      n_cmp++;
      if (ko !== ek) begin
        n_bad++; $display("FAIL seq_k[%0d] got %0d want %0d", i, ko, ek);
      end
      n_cmp++;
      if (vo !== ref_vdc(ek, 3, 7)) begin
        n_bad++;
        $display("FAIL seq_vdc[%0d] got %0d want %0d", i, vo,
                 ref_vdc(ek, 3, 7));
      end
      n_cmp++;
      if (lat != 8) begin
        n_bad++; $display("FAIL seq_latency[%0d] got %0d want 8", i, lat);
      end
    end
  endtask

  task automatic test_base2();
    logic [31:0] vo, ko, ek;
    int lat;
    for (int i = 0; i < 3; i++) begin
      do_pop(1, 1'b0, 32'd0, vo, ko, lat);
      ek = m_cnt_b + 32'd1;
      m_cnt_b = ek;
      n_cmp++;
      if (ko !== ek || vo !== ref_vdc(ek, 2, 11)) begin
        n_bad++;
        $display("FAIL base2[%0d] got k=%0d vdc=%0d want k=%0d vdc=%0d",
                 i, ko, vo, ek, ref_vdc(ek, 2, 11));
      end
      n_cmp++;
      if (lat != 12) begin
        n_bad++; $display("FAIL base2_latency[%0d] got %0d want 12", i, lat);
      end
    end
  endtask

  task automatic test_reseed();
    logic [31:0] vo, ko;
    int lat;
    reseed_a = 1'b1; seed_a = 32'd5;
    @(posedge clk); #1;
    reseed_a = 1'b0;
    m_cnt_a = 32'd5;
    do_pop(0, 1'b0, 32'd0, vo, ko, lat);
    m_cnt_a = m_cnt_a + 32'd1;
    n_cmp++;
    if (ko !== m_cnt_a || vo !== ref_vdc(m_cnt_a, 3, 7)) begin
      n_bad++;
      $display("FAIL reseed_idle got k=%0d vdc=%0d want k=%0d vdc=%0d",
               ko, vo, m_cnt_a, ref_vdc(m_cnt_a, 3, 7));
    end
    do_pop(0, 1'b1, 32'd2186, vo, ko, lat);
    m_cnt_a = 32'd2186 + 32'd1;
    n_cmp++;
    if (ko !== m_cnt_a || vo !== ref_vdc(m_cnt_a, 3, 7)) begin
      n_bad++;
      $display("FAIL reseed_pop got k=%0d vdc=%0d want k=%0d vdc=%0d",
               ko, vo, m_cnt_a, ref_vdc(m_cnt_a, 3, 7));
    end
  endtask

  task automatic test_wrap();
    logic [31:0] vo, ko;
    int lat;
    do_pop(0, 1'b1, 32'hFFFF_FFFF, vo, ko, lat);
    m_cnt_a = 32'hFFFF_FFFF + 32'd1;
    n_cmp++;
    if (ko !== m_cnt_a || vo !== ref_vdc(m_cnt_a, 3, 7)) begin
      n_bad++;
      $display("FAIL wrap got k=%0d vdc=%0d want k=%0d vdc=%0d",
               ko, vo, m_cnt_a, ref_vdc(m_cnt_a, 3, 7));
    end
    do_pop(0, 1'b0, 32'd0, vo, ko, lat);
    m_cnt_a = m_cnt_a + 32'd1;
    n_cmp++;
    if (ko !== m_cnt_a || vo !== ref_vdc(m_cnt_a, 3, 7)) begin
      n_bad++;
      $display("FAIL wrap_next got k=%0d vdc=%0d want k=%0d vdc=%0d",
               ko, vo, m_cnt_a, ref_vdc(m_cnt_a, 3, 7));
    end
  endtask

  task automatic test_random();
    logic [31:0] vo, ko, sd, ek, ev;
    logic rs;
    int lat, which, gap, sc, el;
    for (int i = 0; i < 20; i++) begin
      which = i % 2;
      rs = ($urandom_range(0, 2) == 0);
      sd = $urandom;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
      end
      do_pop(which, rs, sd, vo, ko, lat);
      sc = (which == 0) ? 7 : 11;
      el = sc + 1;
      if (which == 0) begin
        m_cnt_a = (rs ? sd : m_cnt_a) + 32'd1;
        ek = m_cnt_a;
        ev = ref_vdc(ek, 3, 7);
      end else begin
        m_cnt_b = (rs ? sd : m_cnt_b) + 32'd1;
        ek = m_cnt_b;
        ev = ref_vdc(ek, 2, 11);
      end
      n_cmp++;
      if (ko !== ek || vo !== ev || lat != el) begin
        n_bad++;
        $display("FAIL rand[%0d] got k=%0d vdc=%0d lat=%0d want %0d/%0d/%0d",
                 i, ko, vo, lat, ek, ev, el);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (which == 0 ? (valid_a !== 1'b0 || vdc_a !== ev)
                     : (valid_b !== 1'b0 || vdc_b !== ev)) begin
        n_bad++;
        $display("FAIL rand_hold[%0d] valid not single or vdc not held", i);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc, nv, last;
    logic [31:0] ek;
    cyc = 0; nv = 0; last = 0;
    pop_a = 1'b1;
    while (nv < 4 && cyc < 80) begin
      @(posedge clk); #1;
      cyc++;
      if (valid_a) begin
        ek = m_cnt_a + 32'd1;
        m_cnt_a = ek;
        n_cmp++;
        if (k_a !== ek || vdc_a !== ref_vdc(ek, 3, 7)) begin
          n_bad++;
          $display("FAIL b2b_data[%0d] got k=%0d vdc=%0d want %0d/%0d",
                   nv, k_a, vdc_a, ek, ref_vdc(ek, 3, 7));
        end
        n_cmp++;
        if ((nv == 0 && cyc != 8) || (nv > 0 && cyc - last != 9)) begin
          n_bad++;
          $display("FAIL b2b_spacing[%0d] got cyc=%0d last=%0d", nv, cyc,
                   last);
        end
        last = cyc;
        nv++;
      end
    end
    pop_a = 1'b0;
    n_cmp++;
    if (nv != 4) begin
      n_bad++; $display("FAIL b2b_count got %0d want 4", nv);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reseed();
    logic [31:0] vo, ko, ek;
    int lat, w;
    pop_a = 1'b1;
    @(posedge clk); #1;
    pop_a = 1'b0;
    ek = m_cnt_a + 32'd1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++;
    if (ready_a !== 1'b0) begin
      n_bad++; $display("FAIL busy_ready got %b want 0", ready_a);
    end
    reseed_a = 1'b1; seed_a = 32'd100; pop_a = 1'b1;
    @(posedge clk); #1;
    reseed_a = 1'b0; pop_a = 1'b0;
    m_cnt_a = 32'd100;
    w = 0;
    while (!valid_a && w < 30) begin
      @(posedge clk); #1;
      w++;
    end
    n_cmp++;
    if (!valid_a || k_a !== ek || vdc_a !== ref_vdc(ek, 3, 7)) begin
      n_bad++;
      $display("FAIL mid_reseed_flight got v=%b k=%0d vdc=%0d want k=%0d",
               valid_a, k_a, vdc_a, ek);
    end
    do_pop(0, 1'b0, 32'd0, vo, ko, lat);
    m_cnt_a = m_cnt_a + 32'd1;
    n_cmp++;
    if (ko !== m_cnt_a || vo !== ref_vdc(m_cnt_a, 3, 7)) begin
      n_bad++;
      $display("FAIL mid_reseed_next got k=%0d vdc=%0d want k=%0d vdc=%0d",
               ko, vo, m_cnt_a, ref_vdc(m_cnt_a, 3, 7));
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] vo, ko;
    int lat, nv;
    pop_a = 1'b1;
    @(posedge clk); #1;
    pop_a = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (ready_a !== 1'b1 || valid_a !== 1'b0 || vdc_a !== 32'd0 ||
        k_a !== 32'd0) begin
      n_bad++;
      $display("FAIL rst_mid got rdy=%b v=%b vdc=%0d k=%0d want 1/0/0/0",
               ready_a, valid_a, vdc_a, k_a);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_cnt_a = '0;
    m_cnt_b = '0;
    nv = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (valid_a) nv++;
    end
    n_cmp++;
    if (nv != 0) begin
      n_bad++; $display("FAIL rst_mid_novalid got %0d pulses want 0", nv);
    end
    do_pop(0, 1'b0, 32'd0, vo, ko, lat);
    m_cnt_a = m_cnt_a + 32'd1;
    n_cmp++;
    if (ko !== m_cnt_a || vo !== ref_vdc(m_cnt_a, 3, 7)) begin
      n_bad++;
      $display("FAIL rst_mid_next got k=%0d vdc=%0d want k=%0d vdc=%0d",
               ko, vo, m_cnt_a, ref_vdc(m_cnt_a, 3, 7));
    end
  endtask

  initial begin
    rst = 1'b1;
    pop_a = 1'b0; reseed_a = 1'b0; seed_a = '0;
    pop_b = 1'b0; reseed_b = 1'b0; seed_b = '0;
    m_cnt_a = '0; m_cnt_b = '0;
    test_reset();
    test_sequence();
    test_base2();
    test_reseed();
    test_wrap();
    test_random();
    test_back_to_back();
    test_mid_reseed();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
